// File: rtl/smax_reduce_if.sv
// fixedp: fixed-point parameter carrier and common ports for the fixed-point
// library blocks.
//   WIDTH  data width of the fixed-point elements
//   clk    single clock, rising-edge active
//   reset  synchronous, active-high reset
// The master modport drives clock and reset (the environment); library blocks
// attach through the slave modport.
interface fixedp #(
    parameter int WIDTH = 16
);
    logic clk;
    logic reset;

    modport master (output clk, output reset);
    modport slave  (input  clk, input  reset);
endinterface

// File: rtl/smax_reduce.sv
// smax_reduce: streaming signed-maximum reduction with argmax.
// Elements arrive one per accepted beat (in_valid && in_ready). A running
// maximum, the index of its first occurrence and the element count are kept.
// When the element flagged in_last is accepted, the updated values are loaded
// into the output registers and held until out_valid && out_ready.
// Ports:
//   g          fixedp.slave: g.clk clock, g.reset sync active-high reset
//   in_valid   element present on in_data
//   in_ready   block can take an element this cycle (combinational)
//   in_data    signed element value, DATA_W bits (must equal g.WIDTH)
//   in_last    element closes the vector
//   out_valid  result present
//   out_ready  downstream takes the result
//   out_max    maximum element of the vector
//   out_index  zero-based position of the first occurrence of the maximum
//   out_count  element count, saturating at 2^INDEX_WIDTH-1
//   out_sat    count saturated; out_index may be wrong
module smax_reduce #(
    parameter int DATA_W      = 16,
    parameter int INDEX_WIDTH = 16
) (
    fixedp.slave                       g,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_max,
    output logic [INDEX_WIDTH-1:0]     out_index,
    output logic [INDEX_WIDTH-1:0]     out_count,
    output logic                       out_sat
);

    // Saturating increment: MSB of the result flags an increment attempted
    // while already at the all-ones ceiling; the count then stays put.
    function automatic logic [INDEX_WIDTH:0] sat_inc(input logic [INDEX_WIDTH-1:0] c);
        if (&c)
            return {1'b1, c};
        else
            return {1'b0, c + INDEX_WIDTH'(1)};
    endfunction

    logic signed [DATA_W-1:0]   run_max;
    logic [INDEX_WIDTH-1:0]     run_idx;
    logic [INDEX_WIDTH-1:0]     cnt;
    logic                       sat;
    logic                       first;

    logic signed [DATA_W-1:0]   nxt_max;
    logic [INDEX_WIDTH-1:0]     nxt_idx;
    logic [INDEX_WIDTH-1:0]     nxt_cnt;
    logic                       nxt_sat;
    logic [INDEX_WIDTH:0]       inc;
    logic                       accept;
    logic                       handoff;

    // A held result blocks intake; releasing it (out_ready) reopens intake in
    // the same cycle so vectors can run back to back.
    assign in_ready = !g.reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    // Running state after folding in the current element. Strict compare keeps
    // the earlier index on ties; cnt is the position of the current element.
    always_comb begin
        nxt_max = run_max;
        nxt_idx = run_idx;
        nxt_cnt = cnt;
        nxt_sat = sat;
        inc     = '0;
        if (first) begin
            nxt_max = in_data;
            nxt_idx = '0;
            nxt_cnt = INDEX_WIDTH'(1);
            nxt_sat = 1'b0;
        end else begin
            inc = sat_inc(cnt);
            if (in_data > run_max) begin
                nxt_max = in_data;
                nxt_idx = cnt;
            end
            nxt_cnt = inc[INDEX_WIDTH-1:0];
            nxt_sat = sat | inc[INDEX_WIDTH];
        end
    end

    // Accumulator and result registers.
    always_ff @(posedge g.clk) begin
        if (g.reset) begin
            run_max   <= '0;
            run_idx   <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_index <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (handoff)
                out_valid <= 1'b0;
            if (accept) begin
                run_max <= nxt_max;
                run_idx <= nxt_idx;
                cnt     <= nxt_cnt;
                sat     <= nxt_sat;
                first   <= in_last;
                // A last element accepted during a handoff reloads the
                // outputs and keeps out_valid high.
                if (in_last) begin
                    out_valid <= 1'b1;
                    out_max   <= nxt_max;
                    out_index <= nxt_idx;
                    out_count <= nxt_cnt;
                    out_sat   <= nxt_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_smax_reduce.sv
// Directed bench for smax_reduce with DATA_W = 16, INDEX_WIDTH = 4.
module tb_smax_reduce;

    fixedp #(.WIDTH(16)) g ();

    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_max;
    logic [3:0]         out_index;
    logic [3:0]         out_count;
    logic               out_sat;

    int n_cmp = 0;
    int n_err = 0;

    smax_reduce #(.DATA_W(16), .INDEX_WIDTH(4)) dut (
        .g         (g),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_index (out_index),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    initial g.clk = 1'b0;
    always #5 g.clk = ~g.clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input longint mx, input longint idx,
                           input longint cn, input longint st);
        chk({tag, "_valid"}, longint'(out_valid), 1);
        chk({tag, "_max"},   longint'(out_max),   mx);
        chk({tag, "_index"}, longint'(out_index), idx);
        chk({tag, "_count"}, longint'(out_count), cn);
        chk({tag, "_sat"},   longint'(out_sat),   st);
    endtask

    // Present one element, wait (bounded) for in_ready, return #1 after the
    // accepting edge with in_valid dropped.
    task automatic beat(input logic signed [15:0] d, input logic l);
        int waitc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge g.clk);
        while (!in_ready && waitc < 50) begin
            @(negedge g.clk);
            waitc++;
        end
        if (!in_ready)
            chk("beat_ready_timeout", longint'(in_ready), 1);
        @(posedge g.clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        g.reset   = 1'b1;

        // Reset state
        repeat (2) @(posedge g.clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_max", longint'(out_max), 0);
        chk("rst_out_index", longint'(out_index), 0);
        chk("rst_out_count", longint'(out_count), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        g.reset = 1'b0;
        #1;
        chk("idle_in_ready", longint'(in_ready), 1);

        // 5,-3,7,7,2: tie on 7 keeps index 2
        beat(16'sd5, 1'b0);
        beat(-16'sd3, 1'b0);
        beat(16'sd7, 1'b0);
        beat(16'sd7, 1'b0);
        beat(16'sd2, 1'b1);
        chk_res("v1", 7, 2, 5, 0);
        @(posedge g.clk);
        #1;
        chk("v1_drop", longint'(out_valid), 0);

        // Most negative value as the maximum, then a single-element vector
        repeat (2) beat(-16'sd32768, 1'b0);
        beat(-16'sd32768, 1'b1);
        chk_res("neg", -32768, 0, 3, 0);
        beat(16'sd100, 1'b1);
        chk_res("single", 100, 0, 1, 0);

        // Backpressure: {1,9} held while a further last element waits
        beat(16'sd1, 1'b0);
        out_ready = 1'b0;
        beat(16'sd9, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'sd4;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge g.clk);
            chk("hold_in_ready", longint'(in_ready), 0);
            chk_res("hold", 9, 1, 2, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", longint'(in_ready), 1);
        chk_res("release_old", 9, 1, 2, 0);
        @(posedge g.clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_res("release_new", 4, 0, 1, 0);
        @(posedge g.clk);
        #1;
        chk("release_drop", longint'(out_valid), 0);

        // Back-to-back vectors at full rate
        beat(16'sd3, 1'b0);
        beat(16'sd8, 1'b1);
        chk_res("b2b_a", 8, 1, 2, 0);
        chk("b2b_a_ready", longint'(in_ready), 1);
        beat(-16'sd1, 1'b1);
        chk_res("b2b_b", -1, 0, 1, 0);
        chk("b2b_b_ready", longint'(in_ready), 1);
        beat(16'sd6, 1'b0);
        chk("b2b_c0_ready", longint'(in_ready), 1);
        beat(16'sd6, 1'b0);
        chk("b2b_c1_ready", longint'(in_ready), 1);
        beat(16'sd6, 1'b1);
        chk_res("b2b_c", 6, 0, 3, 0);
        chk("b2b_c_ready", longint'(in_ready), 1);

        // 17 elements overflow the 4-bit count
        for (int i = 0; i < 17; i++)
            beat(16'(i), (i == 16) ? 1'b1 : 1'b0);
        chk("ovf_valid", longint'(out_valid), 1);
        chk("ovf_max", longint'(out_max), 16);
        chk("ovf_count", longint'(out_count), 15);
        chk("ovf_sat", longint'(out_sat), 1);

        // Reset mid-vector discards the partial accumulation
        beat(16'sd10, 1'b0);
        beat(16'sd20, 1'b0);
        beat(16'sd30, 1'b0);
        g.reset = 1'b1;
        @(negedge g.clk);
        chk("mid_rst_in_ready", longint'(in_ready), 0);
        @(posedge g.clk);
        #1;
        g.reset = 1'b0;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_out_max", longint'(out_max), 0);
        chk("mid_rst_out_index", longint'(out_index), 0);
        chk("mid_rst_out_count", longint'(out_count), 0);
        chk("mid_rst_out_sat", longint'(out_sat), 0);
        beat(16'sd2, 1'b0);
        beat(16'sd5, 1'b1);
        chk_res("post_rst", 5, 1, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
